l2_memory_responder: RTL
========================

L2_MEMORY_RESPONDER -- requirements
Module: l2_memory_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, number of 32-bit words of backing store; power of two, >= 2.
REQ-002 SHALL have parameter LATENCY, default 4, cycles from request acceptance to l2_ready; legal range 1..255.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port l2_request  input  1  initiator request strobe, held high until l2_ready is sampled.
REQ-006 SHALL have port l2_write_enable  input  1  1 = write, 0 = read; qualified by l2_request.
REQ-007 SHALL have port l2_address  input  32  byte address; bits [1:0] ignored.
REQ-008 SHALL have port l2_write_data  input  32  write data.
REQ-009 SHALL have port l2_response_data  output  32  read data, or echoed write data on a write.
REQ-010 SHALL have port l2_ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port r_state  output  2  encoded FSM state: IDLE=0, WAIT=1, RESP=2, RELEASE=3.

Function
REQ-013 SHALL index storage with word index = l2_address[log2(MEM_WORDS)+1:2]; upper address bits ignored (aliasing, no error).
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP, RELEASE; all outputs registered.
REQ-015 IDLE: at an edge with l2_request=1, SHALL latch address, write_enable and write_data, load the latency counter with LATENCY-1, and go to WAIT; otherwise stay in IDLE.
REQ-016 WAIT: SHALL decrement the counter each edge; at the edge where the counter is 0, SHALL go to RESP.
REQ-017 Entering RESP: a read SHALL drive l2_response_data = mem[latched index]; a write SHALL update mem[latched index] with latched data and drive l2_response_data = latched data; l2_ready SHALL be 1 for the RESP cycle only.
REQ-018 Latency: request sampled at edge k SHALL yield l2_ready high in the cycle following edge k+LATENCY, exactly one cycle wide.
REQ-019 RESP SHALL go unconditionally to RELEASE; RELEASE SHALL go to IDLE at the first edge with l2_request=0 and stay in RELEASE otherwise. This prevents re-serving a request still held high.
REQ-020 Inputs changing during WAIT/RESP SHALL NOT affect the transaction in flight. Dropping l2_request mid-transaction SHALL NOT abort it: a write still commits and l2_ready still pulses.
REQ-021 l2_response_data SHALL hold its value until the next RESP entry.
REQ-022 Read-after-write to the same index in consecutive transactions SHALL return the newly written data.
REQ-023 Minimum spacing between consecutive l2_ready pulses SHALL be LATENCY+3 cycles with a compliant initiator (drops request at the edge it samples l2_ready).

Reset
REQ-024 While reset_n=0: state=IDLE, l2_ready=0, busy=0, r_state=0, l2_response_data=0, counter=0, latched request fields=0.
REQ-025 Storage contents SHALL NOT be altered by reset.
REQ-026 reset_n asserted mid-transaction SHALL abandon it immediately: no memory write, no l2_ready pulse. Operation resumes at the first rising edge after reset_n deasserts, starting from IDLE.

Verification
REQ-027 Write then read, LATENCY=4: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 -> each l2_ready arrives exactly 4 cycles after acceptance; read returns 0xDEADBEEF.
REQ-028 Aliasing, MEM_WORDS=1024: write 0x1234_5678 to 0x0000_1004, then read 0x0000_0004 and 0x0000_0007 -> both return 0x1234_5678.
REQ-029 Held request: initiator keeps l2_request high for 3 cycles after l2_ready -> FSM stays in RELEASE with no second l2_ready; returns to IDLE one edge after l2_request falls.
REQ-030 Mid-flight change: l2_address and l2_write_data change during WAIT -> latched values are used; other locations unchanged.
REQ-031 Reset mid-write: reset_n pulsed low in WAIT of a write of 0xAAAA_5555 to 0x40 -> no l2_ready; a following read of 0x40 returns the prior contents.
REQ-032 LATENCY=1 back-to-back reads from a compliant initiator -> l2_ready pulses spaced 4 cycles apart; r_state sequence 0,1,2,3,0 per transaction.

Source files
------------

// File: rtl/l2_memory_responder.sv
// Single-ported L2 backing store behind a request/ready handshake with a fixed
// response latency; a RELEASE state absorbs requests held high after completion.
module l2_memory_responder #(
   parameter int MEM_WORDS = 1024,
   parameter int LATENCY   = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        l2_request,
   input  logic        l2_write_enable,
   input  logic [31:0] l2_address,
   input  logic [31:0] l2_write_data,
   output logic [31:0] l2_response_data,
   output logic        l2_ready,
   output logic        busy,
   output logic [1:0]  r_state
);

   localparam int AW = $clog2(MEM_WORDS);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WAIT    = 2'd1;
   localparam logic [1:0] S_RESP    = 2'd2;
   localparam logic [1:0] S_RELEASE = 2'd3;

   localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

   logic [31:0]   mem [MEM_WORDS];

   logic [1:0]    state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          we_q, we_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   resp_q;
   logic          ready_q;
   logic          busy_q;
   logic          serve;
   logic          unused_addr;

   // Byte-lane bits and bits above the word index are intentionally ignored.
   assign unused_addr = ^{l2_address[31:AW+2], l2_address[1:0]};

   // Transaction completes on the edge that leaves WAIT with the counter at zero.
   assign serve = (state_q == S_WAIT) && (cnt_q == 8'd0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (l2_request) begin
               state_d = S_WAIT;
               cnt_d   = CNT_LOAD;
               idx_d   = l2_address[AW+1:2];
               we_d    = l2_write_enable;
               wdata_d = l2_write_data;
            end
         end
         S_WAIT: begin
            if (cnt_q == 8'd0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_RESP: begin
            state_d = S_RELEASE;
         end
         S_RELEASE: begin
            if (!l2_request) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         wdata_q <= 32'd0;
         resp_q  <= 32'd0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         ready_q <= serve;
         busy_q  <= (state_d != S_IDLE);
         if (serve) begin
            resp_q <= we_q ? wdata_q : mem[idx_q];
         end
      end
   end

   // Storage is deliberately outside the reset domain so contents survive reset.
   always_ff @(posedge clk) begin
      if (serve && we_q) begin
         mem[idx_q] <= wdata_q;
      end
   end

   assign l2_response_data = resp_q;
   assign l2_ready         = ready_q;
   assign busy             = busy_q;
   assign r_state          = state_q;

endmodule
